// File: rtl/yuv_pkg.sv
// Shared types and constants for the UYVY packer: byte-phase enum, packed word
// layout and the chroma offset used when YUV_OFFSET_BINARY_EN is defined.
package yuv_pkg;

  typedef enum logic [1:0] {
    PH_U  = 2'd0,
    PH_Y0 = 2'd1,
    PH_V  = 2'd2,
    PH_Y1 = 2'd3
  } yuv_phase_e;

  typedef struct packed {
    logic [7:0] u;
    logic [7:0] y0;
    logic [7:0] v;
    logic [7:0] y1;
  } uyvy_word_t;

  localparam logic [7:0] CHROMA_OFFSET = 8'h80;

  // Flipping bit 7 maps signed two's-complement chroma onto offset-binary.
  function automatic logic [7:0] to_offset_binary(input logic [7:0] b);
    return b ^ CHROMA_OFFSET;
  endfunction

endpackage

// File: rtl/yuv_word_fifo.sv
// Synchronous show-ahead FIFO of UYVY words with an up/down occupancy count.
// Full/empty come from the count so the pointers can wrap freely.
module yuv_word_fifo
  import yuv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  uyvy_word_t               din,
  output uyvy_word_t               dout,
  output logic                     out_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  uyvy_word_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            empty;
  logic            do_push;
  logic            do_pop;

  assign empty     = (level == '0);
  assign full      = (level == LW'(DEPTH));
  assign out_valid = !empty;
  assign do_pop    = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push   = push && (!full || do_pop);
  assign dout      = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/yuv422_packer.sv
// Packs the CTE's U,Y0,V,Y1 byte stream into 32-bit UYVY words and queues them
// for the frame-store writer. Define YUV_OFFSET_BINARY_EN to convert chroma to offset-binary.
module yuv422_packer
  import yuv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic [7:0]               yuv_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  yuv_phase_e  phase;
  logic [7:0]  u_q;
  logic [7:0]  y0_q;
  logic [7:0]  v_q;
  logic [7:0]  chroma_in;
  logic        push;
  logic        pop;
  logic        fifo_full;
  uyvy_word_t  push_word;
  uyvy_word_t  head_word;

`ifdef YUV_OFFSET_BINARY_EN
  assign chroma_in = to_offset_binary(yuv_in);
`else
  assign chroma_in = yuv_in;
`endif

  // The Y1 byte bypasses its lane and goes straight into the pushed word.
  assign push      = in_valid && !clear && (phase == PH_Y1);
  assign pop       = out_valid && out_ready;
  assign push_word = '{u: u_q, y0: y0_q, v: v_q, y1: yuv_in};
  assign out_data  = head_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase    <= PH_U;
      u_q      <= '0;
      y0_q     <= '0;
      v_q      <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      phase    <= PH_U;
      overflow <= 1'b0;
    end else if (in_valid) begin
      case (phase)
        PH_U: begin
          u_q   <= chroma_in;
          phase <= PH_Y0;
        end
        PH_Y0: begin
          y0_q  <= yuv_in;
          phase <= PH_V;
        end
        PH_V: begin
          v_q   <= chroma_in;
          phase <= PH_Y1;
        end
        PH_Y1: begin
          phase <= PH_U;
          if (fifo_full && !pop) begin
            overflow <= 1'b1;
          end
        end
        default: phase <= PH_U;
      endcase
    end
  end

  yuv_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .din       (push_word),
    .dout      (head_word),
    .out_valid (out_valid),
    .full      (fifo_full),
    .level     (level)
  );

endmodule
